summation_control: RTL

//  FSM that sequences the summation datapath (accumulator, adder, down-counter).
//  Run flow: clear the sum, load the term count, take one operand per in_valid/in_ready handshake,

---
 rtl/summation_control_if.sv | 22 ++
 rtl/summation_control.sv | 103 ++++++++++
 2 files changed

// File: rtl/summation_control_if.sv
// Operand handshake plus datapath control/status lines for summation_control.
// master = controller side, slave = operand source / datapath side.
interface summation_control_if;
  logic in_valid;
  logic in_ready;
  logic nill;
  logic overflow;
  logic set;
  logic cac;
  logic rac;
  logic dec;

  modport master (
    input  in_valid, nill, overflow,
    output in_ready, set, cac, rac, dec
  );

  modport slave (
    output in_valid, nill, overflow,
    input  in_ready, set, cac, rac, dec
  );
endinterface

// File: rtl/summation_control.sv
// Sequencer for the summation datapath: clear, load count, accumulate
// one operand per handshake, then flag done or err.
module summation_control #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  summation_control_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_FETCH,
    S_FIN,
    S_FAIL
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] wait_q;
  logic            live;
  logic            timed_out;

  // reset and abort both silence every control in the cycle they appear
  assign live      = !abort && !rst;
  assign timed_out = (TIMEOUT != 0) && (wait_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wait_q <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) state <= S_INIT;
        end
        S_INIT: begin
          done   <= 1'b0;
          err    <= 1'b0;
          wait_q <= '0;
          state  <= abort ? S_IDLE : S_CHECK;
        end
        S_CHECK: begin
          if (abort)         state <= S_IDLE;
          else if (bus.nill) state <= S_FIN;
          else               state <= S_FETCH;
        end
        S_FETCH: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (bus.in_valid) begin
            wait_q <= '0;
            state  <= bus.overflow ? S_FAIL : S_CHECK;
          end else if (timed_out) begin
            state <= S_FAIL;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_FAIL: begin
          err   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state != S_IDLE);
    bus.set      = 1'b0;
    bus.cac      = 1'b0;
    bus.in_ready = 1'b0;
    bus.rac      = 1'b0;
    bus.dec      = 1'b0;
    unique case (1'b1)
      live && (state == S_INIT): begin
        bus.set = 1'b1;
        bus.cac = 1'b1;
      end
      live && (state == S_FETCH): begin
        bus.in_ready = 1'b1;
        bus.rac      = bus.in_valid && !bus.overflow;
        bus.dec      = bus.in_valid && !bus.overflow;
      end
      default: ;
    endcase
  end
endmodule
